screen_scanout: RTL and testbench
=================================

SCREEN_SCANOUT -- requirements
Module: screen_scanout

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync widths in pixels; H_TOTAL = 800.
REQ-003 Parameter V_ACTIVE, 480, visible lines; V_FP/V_SYNC/V_BP, 10/2/33; V_TOTAL = 525.
REQ-004 Parameter X0, 64, first column of the 512x256 Hack image (X0 >= 2, X0+512 <= H_ACTIVE).
REQ-005 Parameter Y0, 112, first line of the Hack image (Y0+256 <= V_ACTIVE).
REQ-006 Parameter BORDER, 4'h0, colour nibble driven on all three channels in active area outside the image.
REQ-007 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 pix_ce  in  1  pixel tick; counters and pixel pipeline advance only on clk edges with pix_ce=1.
REQ-010 screen_read_address  out  13  word address into screen RAM (row*32 + word).
REQ-011 read_value  in  16  screen RAM data, valid exactly one clk after screen_read_address changes.
REQ-012 vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-013 vga_hs, vga_vs  out  1 each  syncs, active low.
REQ-014 frame_start  out  1  one-clk pulse on the tick where (h,v) = (0,0).

Function
REQ-015 h counts 0..H_TOTAL-1 on each tick, wraps to 0 and increments v; v wraps V_TOTAL-1 -> 0.
REQ-016 pix_ce=0 freezes h, v, shift register and all outputs.
REQ-017 All outputs registered; outputs for position (h,v) appear the clk after the tick with counters at (h,v) and hold until the next tick.
REQ-018 vga_hs=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else 1.
REQ-019 vga_vs=0 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else 1.
REQ-020 Blanking (h>=H_ACTIVE or v>=V_ACTIVE): rgb = 0.
REQ-021 Active, outside image: rgb = BORDER on all channels.
REQ-022 Image region (X0<=h<X0+512, Y0<=v<Y0+256): row = v-Y0, col = h-X0, word g = col>>4, bit = col[3:0].
REQ-023 Pixel colour: word bit[col[3:0]] (bit 0 leftmost) = 1 -> rgb 0 (black); = 0 -> rgb F (white).
REQ-024 Fetch: on the tick with h = X0+16g-2 (g=0..31) in an image line, screen_read_address <= row*32+g; read_value captured one clk later into a prefetch register.
REQ-025 Shift register loads prefetch register on tick h = X0+16g and shifts right by one on each following tick.
REQ-026 screen_read_address holds its last value outside fetch ticks; never exceeds 8191.
REQ-027 Fetch correctness holds for any pix_ce pattern including pix_ce=1 every clk.
REQ-028 frame_start is high for exactly one clk per frame, aligned with outputs for (0,0).

Reset
REQ-029 While reset=1 at a clk edge: h=0, v=0, shift and prefetch registers 0, screen_read_address=0, rgb=0, vga_hs=1, vga_vs=1, frame_start=0.
REQ-030 Reset mid-line or mid-frame aborts immediately; first tick after release is (0,0) and asserts frame_start.
REQ-031 reset takes priority over pix_ce.

Structure
REQ-032 Timing defaults, X0/Y0 and image size constants (512, 256, 32 words/row) live in shared package hack_vga_pkg.
REQ-033 h/v counters and sync generation form sub-module vga_timing; fetch and shift pipeline stay in screen_scanout.

Verification
REQ-034 pix_ce=1 constant, reset 3 clks then release -> hs low 96 ticks every 800; vs low ticks on lines 490,491; frame every 420000 ticks.
REQ-035 RAM model word0=16'h0001, rest 0 -> pixel (64,112) rgb 0, (65,112) rgb F, border pixel (0,0) rgb BORDER.
REQ-036 word 8191=16'h8000 -> only pixel (575,367) black; address 8191 issued at h=558, v=367.
REQ-037 pix_ce toggling 1-0-1-0 -> output stream identical to REQ-035 at half rate, no fetch miss.
REQ-038 reset asserted at (300,200) for 1 clk -> next output position (0,0), frame_start pulse, syncs 1 during reset.
REQ-039 Random RAM contents, full frame -> scoreboard matches all 131072 image pixels.

Source files
------------

// File: rtl/hack_vga_pkg.sv
// Shared timing defaults, Hack image geometry and pixel types for the scanout path.
package hack_vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned X0_DEF = 64;
  localparam int unsigned Y0_DEF = 112;

  localparam int unsigned IMG_W         = 512;
  localparam int unsigned IMG_H         = 256;
  localparam int unsigned WORDS_PER_ROW = 32;
  localparam int unsigned WORD_BITS     = 16;

  // Counter width covers totals up to 1024 pixels/lines.
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned ROW_W      = 8;
  localparam int unsigned WORD_IDX_W = 5;
  localparam int unsigned ADDR_W     = ROW_W + WORD_IDX_W;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical position counters with registered sync and frame-start outputs.
module vga_timing
  import hack_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic hs_c;
  logic vs_c;
  logic origin_c;

  // Sync decode of the current position, registered on the same tick as the pixel.
  always_comb begin
    hs_c     = !((h >= HS_FIRST) && (h <= HS_LAST));
    vs_c     = !((v >= VS_FIRST) && (v <= VS_LAST));
    origin_c = (h == '0) && (v == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        vga_hs      <= hs_c;
        vga_vs      <= vs_c;
        frame_start <= origin_c;
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/screen_scanout.sv
// Scans the 512x256 Hack screen RAM out as VGA pixels inside a bordered active area.
module screen_scanout
  import hack_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned X0       = X0_DEF,
  parameter int unsigned Y0       = Y0_DEF,
  parameter logic [3:0]  BORDER   = 4'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  output logic [ADDR_W-1:0] screen_read_address,
  input  logic [15:0]       read_value,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] IMG_X0   = CNT_W'(X0);
  localparam logic [CNT_W-1:0] IMG_X1   = CNT_W'(X0 + IMG_W);
  localparam logic [CNT_W-1:0] IMG_Y0   = CNT_W'(Y0);
  localparam logic [CNT_W-1:0] IMG_Y1   = CNT_W'(Y0 + IMG_H);
  localparam logic [CNT_W-1:0] FETCH_X0 = CNT_W'(X0 - 2);
  localparam logic [CNT_W-1:0] FETCH_X1 = CNT_W'(X0 + IMG_W - 2);

  logic [CNT_W-1:0]     h;
  logic [CNT_W-1:0]     v;
  logic [3:0]           col_lsb;
  logic [8:0]           fcol;
  logic [ROW_W-1:0]     row;
  logic                 in_rows;
  logic                 in_img;
  logic                 active;
  logic                 fetch;
  logic                 load;
  logic                 pix_bit;
  logic [3:0]           img_nib;
  rgb_t                 pix_nxt;
  logic [WORD_BITS-1:0] prefetch;
  logic [WORD_BITS-1:0] shift;
  logic                 fetch_pending;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .pix_ce      (pix_ce),
    .h           (h),
    .v           (v),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  // Region decode; fcol is offset by 2 so fetches land two ticks before each word.
  always_comb begin
    col_lsb = 4'(h - IMG_X0);
    fcol    = 9'(h - FETCH_X0);
    row     = ROW_W'(v - IMG_Y0);
    in_rows = (v >= IMG_Y0) && (v < IMG_Y1);
    in_img  = in_rows && (h >= IMG_X0) && (h < IMG_X1);
    active  = (h < H_ACT) && (v < V_ACT);
    fetch   = in_rows && (h >= FETCH_X0) && (h < FETCH_X1) && (fcol[3:0] == 4'd0);
    load    = in_img && (col_lsb == 4'd0);
    // On a load tick the shifter is not yet filled, so the first bit comes from prefetch.
    pix_bit = load ? prefetch[0] : shift[1];
    img_nib = pix_bit ? 4'h0 : 4'hF;
    pix_nxt = '0;
    if (active) begin
      if (in_img) pix_nxt = {3{img_nib}};
      else        pix_nxt = {3{BORDER}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      screen_read_address <= '0;
      prefetch            <= '0;
      shift               <= '0;
      fetch_pending       <= 1'b0;
      vga_r               <= '0;
      vga_g               <= '0;
      vga_b               <= '0;
    end else begin
      // RAM data is captured one clk after the address moves, independent of pix_ce.
      fetch_pending <= pix_ce && fetch;
      if (fetch_pending) prefetch <= read_value;
      if (pix_ce) begin
        if (fetch) screen_read_address <= {row, fcol[WORD_IDX_W+3:4]};
        shift <= load ? prefetch : (shift >> 1);
        vga_r <= pix_nxt.r;
        vga_g <= pix_nxt.g;
        vga_b <= pix_nxt.b;
      end
    end
  end

endmodule

// File: tb/tb_screen_scanout.sv
// Randomized scoreboard bench for screen_scanout against a position-based pixel model.
module tb_screen_scanout;

  // Compact but legal geometry so many image lines fit in a short run.
  localparam int H_ACT  = 520;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 4;
  localparam int V_ACT  = 260;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam int X0     = 4;
  localparam int Y0     = 3;
  localparam logic [3:0] BORDER = 4'h5;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [9:0]  ph;
    logic [9:0]  pv;
    logic [3:0]  c;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [12:0] addr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pix_ce;
  logic [12:0] screen_read_address;
  logic [15:0] read_value;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  logic [15:0] mem [0:8191];
  exp_t        sb[$];
  int          mh, mv, maddr;
  int          ram_req, ram_seen, ram_addr;
  int          n_checks, n_fail;
  logic        end_check;

  screen_scanout #(
    .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .X0 (X0), .Y0 (Y0), .BORDER (BORDER)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pix_ce              (pix_ce),
    .screen_read_address (screen_read_address),
    .read_value          (read_value),
    .vga_r               (vga_r),
    .vga_g               (vga_g),
    .vga_b               (vga_b),
    .vga_hs              (vga_hs),
    .vga_vs              (vga_vs),
    .frame_start         (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: data valid only for the one clk after a fetch tick, garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (ram_req != ram_seen) begin
      ram_seen   = ram_req;
      read_value = mem[ram_addr];
    end else begin
      read_value = 16'($urandom);
    end
  end

  task automatic check(input string name, input exp_t e);
    n_checks++;
    if (vga_r !== e.c || vga_g !== e.c || vga_b !== e.c || vga_hs !== e.hs ||
        vga_vs !== e.vs || frame_start !== e.fs || screen_read_address !== e.addr) begin
      n_fail++;
      $display("FAIL %s pos=(%0d,%0d) t=%0t: got rgb=%h%h%h hs=%b vs=%b fs=%b addr=%0d, want rgb=%h%h%h hs=%b vs=%b fs=%b addr=%0d",
               name, e.ph, e.pv, $time, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start,
               screen_read_address, e.c, e.c, e.c, e.hs, e.vs, e.fs, e.addr);
    end
  endtask

  // Monitor: pops one expectation per tick, checks hold between ticks and reset values.
  always @(posedge clk) begin : monitor
    logic r_s, ce_s, drained;
    exp_t e, last, rst_e;
    r_s  = reset;
    ce_s = pix_ce;
    #1;
    rst_e    = '0;
    rst_e.hs = 1'b1;
    rst_e.vs = 1'b1;
    if (r_s) begin
      check("reset", rst_e);
      last = rst_e;
    end else if (ce_s) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got an output tick with no expected entry, want 1 entry");
      end else begin
        n_checks--;
        e = sb.pop_front();
        check("pixel", e);
        last = e;
      end
    end else begin
      e    = last;
      e.fs = 1'b0;
      check("hold", e);
    end
    if (end_check && drained !== 1'b1) begin
      drained = 1'b1;
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL sb_drain: got %0d undelivered outputs, want 0", sb.size());
      end
    end
  end

  // One clk of stimulus; on a tick the model's expectation for (mh,mv) is queued.
  task automatic drive(input logic ce, input logic rst);
    exp_t        e;
    int          col, gx;
    logic [15:0] w;
    @(negedge clk);
    pix_ce = ce;
    reset  = rst;
    if (rst) begin
      mh = 0; mv = 0; maddr = 0;
    end else if (ce) begin
      e    = '0;
      e.ph = 10'(mh);
      e.pv = 10'(mv);
      e.hs = (mh >= H_ACT + H_FP && mh < H_ACT + H_FP + H_SYNC) ? 1'b0 : 1'b1;
      e.vs = (mv >= V_ACT + V_FP && mv < V_ACT + V_FP + V_SYNC) ? 1'b0 : 1'b1;
      e.fs = (mh == 0 && mv == 0);
      if (mh >= H_ACT || mv >= V_ACT) e.c = 4'h0;
      else if (mh >= X0 && mh < X0 + 512 && mv >= Y0 && mv < Y0 + 256) begin
        col = mh - X0;
        w   = mem[(mv - Y0) * 32 + col / 16];
        e.c = w[col % 16] ? 4'h0 : 4'hF;
      end else e.c = BORDER;
      gx = mh + 2 - X0;
      if (mv >= Y0 && mv < Y0 + 256 && gx >= 0 && gx < 512 && gx % 16 == 0) begin
        maddr    = (mv - Y0) * 32 + gx / 16;
        ram_addr = maddr;
        ram_req++;
      end
      e.addr = 13'(maddr);
      sb.push_back(e);
      mh++;
      if (mh == H_TOT) begin
        mh = 0;
        mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end
    end
  endtask

  // mode 0: tick every clk, 1: alternate idle/tick, 2: random idle gaps.
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1) drive(1'b0, 1'b0);
      if (mode == 2) while ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    pix_ce     = 1'b0;
    read_value = '0;
    end_check  = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    mh = 0; mv = 0; maddr = 0;
    ram_req = 0; ram_seen = 0; ram_addr = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);

    repeat (3) drive(1'b0, 1'b1);
    run(20 * H_TOT, 0);
    run(3 * H_TOT, 1);
    run(3 * H_TOT, 2);
    while (mh != 300) run(1, 0);

    // Mid-line reset, then a sparse pattern exercising the first and last word bits.
    drive(1'b1, 1'b1);
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0001;
    mem[63] = 16'h8000;
    run(6 * H_TOT, 1);
    run(2 * H_TOT, 0);

    repeat (2) drive(1'b0, 1'b0);
    end_check = 1'b1;
    repeat (3) drive(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
